// File: rtl/collatz_stepper_if.sv
// Start/ready/finish handshake bundle for the collatz_stepper kernel.
// start is taken on a clock edge only while ready=1; finish pulses once when results become valid.
interface collatz_stepper_if #(
  parameter int WIDTH     = 32,
  parameter int CNT_WIDTH = 32
);
  logic                 start;
  logic [WIDTH-1:0]     n;
  logic                 ready;
  logic                 finish;
  logic [CNT_WIDTH-1:0] return_val;
  logic [1:0]           status;
  logic [WIDTH-1:0]     peak;

  modport master (
    output start, n,
    input  ready, finish, return_val, status, peak
  );

  modport slave (
    input  start, n,
    output ready, finish, return_val, status, peak
  );
endinterface

// File: rtl/collatz_stepper.sv
// Collatz step-count engine: one step per cycle, bounded by a step limit, with overflow and zero detection.
// Optional peak tracking is built when COLLATZ_PEAK_TRACK_EN is defined; otherwise peak is tied to 0.
module collatz_stepper #(
  parameter int WIDTH     = 32,
  parameter int CNT_WIDTH = 32,
  parameter int MAX_STEPS = 1000
) (
  input  logic                clk,
  input  logic                reset,
  collatz_stepper_if.slave    bus,
  output logic [1:0]          state_dbg
);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

  localparam logic [1:0] ST_OK      = 2'd0;
  localparam logic [1:0] ST_TIMEOUT = 2'd1;
  localparam logic [1:0] ST_OVF     = 2'd2;
  localparam logic [1:0] ST_ZERO    = 2'd3;

  localparam logic [CNT_WIDTH-1:0] LIMIT = CNT_WIDTH'(MAX_STEPS);

  state_t               state, state_nxt;
  logic [WIDTH-1:0]     value_q;
  logic [CNT_WIDTH-1:0] count_q;
  logic [CNT_WIDTH-1:0] ret_q;
  logic [1:0]           status_q;
  logic                 finish_q;

  logic [WIDTH+1:0]     sum;
  logic                 ovf;
  logic                 limit_hit;
  logic [WIDTH-1:0]     step_val;
  logic                 term;
  logic [1:0]           term_status;

  // 3n+1 is formed in WIDTH+2 bits so any carry out of WIDTH flags overflow.
  assign sum       = {2'b00, value_q} + {1'b0, value_q, 1'b0} + {{(WIDTH+1){1'b0}}, 1'b1};
  assign ovf       = value_q[0] & (|sum[WIDTH+1:WIDTH]);
  assign step_val  = value_q[0] ? sum[WIDTH-1:0] : (value_q >> 1);
  assign limit_hit = (MAX_STEPS != 0) ? (count_q == LIMIT) : (&count_q);

  always_comb begin
    state_nxt   = state;
    term        = 1'b0;
    term_status = ST_OK;
    case (state)
      IDLE: if (bus.start) state_nxt = RUN;
      RUN: begin
        if (value_q == '0) begin
          term = 1'b1; term_status = ST_ZERO;
        end else if (value_q == WIDTH'(1)) begin
          term = 1'b1; term_status = ST_OK;
        end else if (limit_hit) begin
          term = 1'b1; term_status = ST_TIMEOUT;
        end else if (ovf) begin
          term = 1'b1; term_status = ST_OVF;
        end
        if (term) state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      value_q  <= '0;
      count_q  <= '0;
      ret_q    <= '0;
      status_q <= ST_OK;
      finish_q <= 1'b0;
    end else begin
      state    <= state_nxt;
      finish_q <= (state == RUN) && term;
      if (state == IDLE && bus.start) begin
        value_q  <= bus.n;
        count_q  <= '0;
        ret_q    <= '0;
        status_q <= ST_OK;
      end else if (state == RUN) begin
        if (term) begin
          ret_q    <= count_q;
          status_q <= term_status;
        end else begin
          value_q <= step_val;
          count_q <= count_q + 1'b1;
        end
      end
    end
  end

`ifdef COLLATZ_PEAK_TRACK_EN
  logic [WIDTH-1:0] peak_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      peak_q <= '0;
    end else if (state == IDLE && bus.start) begin
      peak_q <= bus.n;
    end else if (state == RUN && !term && step_val > peak_q) begin
      peak_q <= step_val;
    end
  end

  assign bus.peak = peak_q;
`else
  assign bus.peak = '0;
`endif

  assign bus.ready      = (state == IDLE) & ~reset;
  assign bus.finish     = finish_q;
  assign bus.return_val = ret_q;
  assign bus.status     = status_q;
  assign state_dbg      = state;

endmodule

// File: tb/tb_collatz_stepper.sv
// Bench for collatz_stepper: five parameter variants share one start/n drive; results checked
// against hand-derived vectors and a behavioural step model through per-instance expected queues.
module tb_collatz_stepper;

  localparam int CLK_HALF = 5;
`ifdef COLLATZ_PEAK_TRACK_EN
  localparam bit PEAK_EN = 1'b1;
`else
  localparam bit PEAK_EN = 1'b0;
`endif

  localparam logic [1:0] ST_OK = 2'd0, ST_TO = 2'd1, ST_OVF = 2'd2, ST_ZERO = 2'd3;

  typedef struct packed {
    logic [31:0] fin_cyc;
    logic [31:0] ret;
    logic [1:0]  st;
    logic [31:0] pk;
  } exp_t;

  typedef struct {
    int          id;
    logic [31:0] n;
    logic [31:0] ret;
    logic [1:0]  st;
    logic [31:0] pk;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [31:0] n_drv = '0;
  int unsigned cyc = 0;
  int          errors = 0;
  int          checks = 0;
  exp_t        exp_q[5][$];

  // ---------------- clock / reset ----------------
  always #CLK_HALF clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #(CLK_HALF * 2 * 60000);
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  // ---------------- DUT instances ----------------
  // 0: defaults, 1: unlimited, 2: MAX_STEPS=10, 3: 3-bit counter unlimited, 4: WIDTH=8
  collatz_stepper_if #(.WIDTH(32), .CNT_WIDTH(32)) if_d ();
  collatz_stepper_if #(.WIDTH(32), .CNT_WIDTH(32)) if_u ();
  collatz_stepper_if #(.WIDTH(32), .CNT_WIDTH(32)) if_l ();
  collatz_stepper_if #(.WIDTH(32), .CNT_WIDTH(3))  if_s ();
  collatz_stepper_if #(.WIDTH(8),  .CNT_WIDTH(32)) if_w ();
  logic [1:0] dbg_d, dbg_u, dbg_l, dbg_s, dbg_w;

  assign if_d.start = start; assign if_d.n = n_drv;
  assign if_u.start = start; assign if_u.n = n_drv;
  assign if_l.start = start; assign if_l.n = n_drv;
  assign if_s.start = start; assign if_s.n = n_drv;
  assign if_w.start = start; assign if_w.n = n_drv[7:0];

  collatz_stepper #(.WIDTH(32), .CNT_WIDTH(32), .MAX_STEPS(1000)) u_d (.clk(clk), .reset(reset), .bus(if_d), .state_dbg(dbg_d));
  collatz_stepper #(.WIDTH(32), .CNT_WIDTH(32), .MAX_STEPS(0))    u_u (.clk(clk), .reset(reset), .bus(if_u), .state_dbg(dbg_u));
  collatz_stepper #(.WIDTH(32), .CNT_WIDTH(32), .MAX_STEPS(10))   u_l (.clk(clk), .reset(reset), .bus(if_l), .state_dbg(dbg_l));
  collatz_stepper #(.WIDTH(32), .CNT_WIDTH(3),  .MAX_STEPS(0))    u_s (.clk(clk), .reset(reset), .bus(if_s), .state_dbg(dbg_s));
  collatz_stepper #(.WIDTH(8),  .CNT_WIDTH(32), .MAX_STEPS(1000)) u_w (.clk(clk), .reset(reset), .bus(if_w), .state_dbg(dbg_w));

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  function automatic exp_t model(input longint unsigned n0, input int width, input int cw,
                                 input longint unsigned max_steps);
    longint unsigned v, cnt, pk, all_ones;
    exp_t e;
    e = '0; v = n0; cnt = 0; pk = n0;
    all_ones = (64'd1 << cw) - 1;
    for (int i = 0; i < 200000; i++) begin
      if (v == 0) begin e.st = ST_ZERO; break; end
      if (v == 1) begin e.st = ST_OK; break; end
      if (max_steps != 0 && cnt == max_steps) begin e.st = ST_TO; break; end
      if (max_steps == 0 && cnt == all_ones) begin e.st = ST_TO; break; end
      if (v[0] && (3 * v + 1) >= (64'd1 << width)) begin e.st = ST_OVF; break; end
      v   = v[0] ? (3 * v + 1) : (v / 2);
      cnt = cnt + 1;
      if (v > pk) pk = v;
    end
    e.ret = cnt[31:0];
    e.pk  = PEAK_EN ? pk[31:0] : 32'd0;
    return e;
  endfunction

  function automatic bit all_ready();
    return if_d.ready & if_u.ready & if_l.ready & if_s.ready & if_w.ready;
  endfunction

  // ---------------- scoreboard ----------------
  task automatic check_finish(input int id, input string name, input logic [31:0] ret,
                              input logic [1:0] st, input logic [31:0] pk, input logic rdy);
    exp_t e;
    if (exp_q[id].size() == 0) begin
      check({name, " unexpected_finish"}, 64'd1, 64'd0);
    end else begin
      e = exp_q[id].pop_front();
      check({name, " finish_cycle"}, 64'(cyc), 64'(e.fin_cyc));
      check({name, " return_val"}, 64'(ret), 64'(e.ret));
      check({name, " status"}, 64'(st), 64'(e.st));
      check({name, " peak"}, 64'(pk), 64'(e.pk));
      check({name, " ready_at_finish"}, 64'(rdy), 64'd0);
    end
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      if (if_d.finish) check_finish(0, "dflt", if_d.return_val, if_d.status, if_d.peak, if_d.ready);
      if (if_u.finish) check_finish(1, "unl",  if_u.return_val, if_u.status, if_u.peak, if_u.ready);
      if (if_l.finish) check_finish(2, "lim",  if_l.return_val, if_l.status, if_l.peak, if_l.ready);
      if (if_s.finish) check_finish(3, "sat",  32'(if_s.return_val), if_s.status, if_s.peak, if_s.ready);
      if (if_w.finish) check_finish(4, "w8",   if_w.return_val, if_w.status, 32'(if_w.peak), if_w.ready);
    end
  end

  // ---------------- driver ----------------
  task automatic wait_all_ready();
    for (int i = 0; i < 3000 && !all_ready(); i++) @(negedge clk);
    if (!all_ready()) check("wait_ready timeout", 64'd0, 64'd1);
  endtask

  // Drives one start; instance tid takes the hand-written expectation, the rest use the model.
  task automatic launch(input logic [31:0] nv, input int tid, input vec_t v, output int unsigned s);
    exp_t e;
    wait_all_ready();
    start = 1'b1;
    n_drv = nv;
    s = cyc;
    for (int id = 0; id < 5; id++) begin
      case (id)
        0:       e = model(nv, 32, 32, 1000);
        1:       e = model(nv, 32, 32, 0);
        2:       e = model(nv, 32, 32, 10);
        3:       e = model(nv, 32, 3, 0);
        default: e = model(nv & 32'hff, 8, 32, 1000);
      endcase
      if (id == tid) begin
        e.ret = v.ret; e.st = v.st; e.pk = PEAK_EN ? v.pk : 32'd0;
      end
      e.fin_cyc = s + e.ret + 2;
      exp_q[id].push_back(e);
    end
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // ---------------- test ----------------
  vec_t tbl[10];
  vec_t none;

  initial begin
    int unsigned s;
    none = '{id: -1, n: 0, ret: 0, st: 0, pk: 0};
    tbl[0] = '{id: 0, n: 1,   ret: 0,   st: ST_OK,   pk: 1};
    tbl[1] = '{id: 0, n: 0,   ret: 0,   st: ST_ZERO, pk: 0};
    tbl[2] = '{id: 0, n: 6,   ret: 8,   st: ST_OK,   pk: 16};
    tbl[3] = '{id: 0, n: 3,   ret: 7,   st: ST_OK,   pk: 16};
    tbl[4] = '{id: 0, n: 7,   ret: 16,  st: ST_OK,   pk: 52};
    tbl[5] = '{id: 0, n: 2,   ret: 1,   st: ST_OK,   pk: 2};
    tbl[6] = '{id: 1, n: 27,  ret: 111, st: ST_OK,   pk: 9232};
    tbl[7] = '{id: 2, n: 27,  ret: 10,  st: ST_TO,   pk: 214};
    tbl[8] = '{id: 3, n: 6,   ret: 7,   st: ST_TO,   pk: 16};
    tbl[9] = '{id: 4, n: 255, ret: 0,   st: ST_OVF,  pk: 255};

    // reset values, with start held high to show reset wins
    start = 1'b1;
    repeat (3) @(negedge clk);
    check("rst ready", 64'(if_d.ready), 64'd0);
    check("rst finish", 64'(if_d.finish), 64'd0);
    check("rst return_val", 64'(if_d.return_val), 64'd0);
    check("rst status", 64'(if_d.status), 64'd0);
    check("rst peak", 64'(if_d.peak), 64'd0);
    check("rst state", 64'(dbg_d), 64'd0);
    start = 1'b0;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("post_rst ready", 64'(if_d.ready), 64'd1);

    for (int i = 0; i < 10; i++) launch(tbl[i].n, tbl[i].id, tbl[i], s);
    for (int i = 0; i < 4; i++) launch($urandom_range(1, 3000), -1, none, s);

    // abort n=27 with a one-cycle reset in cycle 20
    launch(32'd27, -1, none, s);
    while (cyc < s + 20) @(posedge clk);
    #1 reset = 1'b1;
    for (int id = 0; id < 5; id++) exp_q[id].delete();
    @(negedge clk);
    check("abort ready_in_reset", 64'(if_d.ready), 64'd0);
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("abort ready", 64'(if_d.ready), 64'd1);
    check("abort return_val", 64'(if_d.return_val), 64'd0);
    check("abort status", 64'(if_d.status), 64'd0);
    check("abort peak", 64'(if_u.peak), 64'd0);
    check("abort finish", 64'(if_d.finish), 64'd0);

    // restart with n=6 and fire an ignored start while busy
    launch(32'd6, 0, tbl[2], s);
    @(negedge clk);
    @(negedge clk);
    start = 1'b1;
    n_drv = 32'd99;
    @(negedge clk);
    start = 1'b0;

    wait_all_ready();
    repeat (200) @(negedge clk);
    for (int id = 0; id < 5; id++) check($sformatf("pending_q%0d", id), 64'(exp_q[id].size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
